// File: rtl/cordic_sched.sv
// cordic_sched: round-robin scheduler sharing one cordic pipeline between
// NUM_REQ requesters. Keeps cordic_start high while any op is in flight so the
// start-qualified stages stay aligned with the free-running reciprocal delay
// line. Results are registered and tagged with the requester id.
// Optional: define CORDIC_SCHED_PERF_EN to add perf_ops/perf_bubbles counters.
module cordic_sched #(
    parameter int NUM_REQ    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int LATENCY    = 6,
    parameter int ID_W       = $clog2(NUM_REQ)
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic [NUM_REQ-1:0]               req_valid,
    output logic [NUM_REQ-1:0]               req_ready,
    input  logic [3*NUM_REQ-1:0]             req_mode,
    input  logic [4*NUM_REQ-1:0]             req_shift,
    input  logic [2*DATA_WIDTH*NUM_REQ-1:0]  req_opa,
    input  logic [2*DATA_WIDTH*NUM_REQ-1:0]  req_opb,
    output logic                             cordic_start,
    output logic [2:0]                       cordic_mode,
    output logic [3:0]                       cordic_shift,
    output logic [2*DATA_WIDTH-1:0]          cordic_opa,
    output logic [2*DATA_WIDTH-1:0]          cordic_opb,
    input  logic [2*DATA_WIDTH-1:0]          cordic_data,
    output logic                             rsp_valid,
    output logic [ID_W-1:0]                  rsp_id,
    output logic [2*DATA_WIDTH-1:0]          rsp_data
`ifdef CORDIC_SCHED_PERF_EN
    ,
    output logic [31:0]                      perf_ops,
    output logic [31:0]                      perf_bubbles
`endif
);

    localparam int W2 = 2 * DATA_WIDTH;

    logic [ID_W-1:0] rr_ptr;
    logic [ID_W-1:0] ptr_next;
    logic [ID_W-1:0] cand;
    logic [ID_W-1:0] grant;
    logic            found;
    logic            issue;
    logic [LATENCY:1] occ;
    logic [ID_W-1:0] id_pipe [1:LATENCY];

    // Round-robin search starting at rr_ptr; first valid requester wins.
    always_comb begin
        found = 1'b0;
        grant = '0;
        cand  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = ID_W'((int'(rr_ptr) + int'(i)) % NUM_REQ);
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                grant = cand;
            end
        end
        issue     = found & ~rst;
        req_ready = issue ? (NUM_REQ'(1) << grant) : '0;
        ptr_next  = (grant == ID_W'(NUM_REQ - 1)) ? '0 : grant + 1'b1;
    end

    // Start covers the issue plus every op not yet at the last stage.
    always_comb begin
        cordic_start = issue | ((|occ[LATENCY-1:1]) & ~rst);
    end

    // Operand mux: granted slice on issue, zeros on bubbles and when idle.
    always_comb begin
        cordic_mode  = '0;
        cordic_shift = '0;
        cordic_opa   = '0;
        cordic_opb   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (issue && grant == ID_W'(i)) begin
                cordic_mode  = req_mode[3*i +: 3];
                cordic_shift = req_shift[4*i +: 4];
                cordic_opa   = req_opa[W2*i +: W2];
                cordic_opb   = req_opb[W2*i +: W2];
            end
        end
    end

    // Pointer, occupancy/id tracker and result capture.
    always_ff @(posedge clk) begin
        if (rst) begin
            rr_ptr    <= '0;
            occ       <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_data  <= '0;
            for (int unsigned k = 1; k <= LATENCY; k++) begin
                id_pipe[k] <= '0;
            end
        end else begin
            if (issue) begin
                rr_ptr <= ptr_next;
            end
            if (cordic_start) begin
                occ[1]     <= issue;
                id_pipe[1] <= grant;
                for (int unsigned k = 1; k < LATENCY; k++) begin
                    occ[k+1]     <= occ[k];
                    id_pipe[k+1] <= id_pipe[k];
                end
            end else begin
                // Only the last stage can be occupied here; it drains on capture.
                occ[LATENCY] <= 1'b0;
            end
            rsp_valid <= occ[LATENCY];
            if (occ[LATENCY]) begin
                rsp_data <= cordic_data;
                rsp_id   <= id_pipe[LATENCY];
            end
        end
    end

`ifdef CORDIC_SCHED_PERF_EN
    // Saturating counters of issues and bubble cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_ops     <= '0;
            perf_bubbles <= '0;
        end else begin
            if (issue && perf_ops != '1) begin
                perf_ops <= perf_ops + 32'd1;
            end
            if (cordic_start && !issue && perf_bubbles != '1) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule
